reg_feeder: RTL and testbench
=============================

Name: reg_feeder

Overview:
Upstream source stage for the `register` slice. It accepts words over a valid/ready interface and buffers them in a small FIFO. It drains one word per pop onto the slice's `enable`/`data` inputs, with an optional programmable idle gap between pops. `enable` is a single-cycle qualifier per word, so the slice captures each word exactly once and holds it otherwise.

Parameters:
- WIDTH, 8, data word width; must match the downstream register slice.
- DEPTH, 4, FIFO entries; power of 2, ≥2.
- GAP, 0, idle cycles forced after each pop; range 0..15.

Ports:
- clk  input  1  clock; all logic on posedge.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  upstream word valid.
- in_ready  output  1  FIFO can accept; equals !full.
- in_data  input  WIDTH  upstream word.
- stall  input  1  downstream hold; blocks pops while high.
- flush  input  1  synchronous FIFO clear.
- enable  output  1  registered; one-cycle pulse per delivered word; drives the slice's `enable`.
- data  output  WIDTH  registered; word being delivered; drives the slice's `data`.
- level  output  $clog2(DEPTH)+1  current FIFO occupancy.
- empty  output  1  level==0.
- full  output  1  level==DEPTH.

Behaviour:
- Clock and reset (decided): single clock `clk`; `reset` is synchronous and active-high, sampled at posedge clk only.
- Reset values: enable=0, data=0, level=0, empty=1, full=0, in_ready=1; internal pointers and gap_cnt=0. FIFO contents are don't-care.
- Reset mid-operation: all buffered words are discarded. No enable pulse is issued in the cycle after reset.
- Push rule: push = in_valid && in_ready. Writes mem[wr_ptr] and increments wr_ptr modulo DEPTH.
- in_ready is combinational: in_ready = !full.
- No push when full, even if a pop happens in the same cycle. in_ready does not look ahead.
- Pop condition: pop = !empty && !stall && gap_cnt==0 && !flush.
- On pop at edge k:
  - data <= mem[rd_ptr]; enable <= 1.
  - rd_ptr increments modulo DEPTH.
  - gap_cnt <= GAP.
- Otherwise: enable <= 0 and data holds its last value.
- gap_cnt decrements by 1 each cycle while nonzero, regardless of stall.
- Latency, empty FIFO with gap_cnt==0:
  - Word accepted at edge k gives enable=1 in cycle k+1 to k+2.
  - The slice's outa shows the word after edge k+2.
- Throughput: GAP=0 and no stall gives back-to-back pops, one word per cycle. GAP=g gives one word per g+1 cycles.
- Level update: level += push - pop.
  - Simultaneous push and pop leaves level unchanged.
  - Pointer wrap at DEPTH-1 → 0 must be exercised.
- Flush at edge k:
  - Pointers and level clear; enable <= 0; gap_cnt <= 0.
  - A push in the same cycle is dropped. in_ready is still computed from the pre-flush full flag.
  - Flush overrides pop.
- Stall:
  - Freezes pops only; pushes continue until full.
  - Deasserting stall allows a pop at the very next edge, if gap_cnt==0.
- Ordering: strict FIFO order; no word is duplicated or lost except on flush/reset.
- Synthesisable; no latches. The FIFO memory needs no reset.

Decomposition:
- Package `reg_feeder_pkg`:
  - Function/localparam for pointer width PTR_W = $clog2(DEPTH).
  - LVL_W = PTR_W+1.
  - GAP_W = 4.
  - Parameterised word type word_t [WIDTH-1:0], declared via the typedef in the top module (parameterised).
- One natural sub-module: `reg_feeder_fifo`.
  - Contains the memory, pointers, level, empty and full.
  - Push/pop/flush inputs; rdata output.
- The top level holds the gap counter, pop arbitration and output registers.

Test Plan:
- Reset sequence: assert reset for 2 cycles with in_valid=1 → enable=0, data=0, level=0, in_ready=1 throughout. No push is accepted while reset is high.
- Single word, GAP=0: push 0xA5 at edge k → enable=1, data=0xA5 in cycle k+1..k+2 only. The register slice's outa=0xA5 after edge k+2.
- Fill and wrap, DEPTH=4, stall=1:
  - Push 0x01..0x04 → full=1, in_ready=0, level=4.
  - Offer 0x05 → not accepted.
  - Release stall → enable pulses on 4 consecutive cycles, data 0x01,0x02,0x03,0x04.
  - Then push 0x06..0x08 → delivered in order after pointer wrap.
- GAP=3: push 0x10,0x11,0x12 back-to-back → enable pulses exactly 4 cycles apart, data in order. level peaks at 2, not 3, since the first word pops the cycle after accept.
- Simultaneous push/pop at level 2 → level stays 2 and ordering is preserved.
- Flush with level=3, in_valid=1 in the same cycle → level=0, empty=1, no enable next cycle, the in-flight push is dropped. Then push 0x7E → it is delivered normally.

Source files
------------

// File: rtl/reg_feeder_pkg.sv
// Shared widths for the register-slice feeder: pointer, occupancy and gap-counter sizing.
// Pure constants and helpers; no logic, no latency, no flow control.
package reg_feeder_pkg;

  localparam int GAP_W = 4;

  function automatic int ptr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  function automatic int lvl_w(input int depth);
    return ptr_w(depth) + 1;
  endfunction

endpackage

// File: rtl/reg_feeder_if.sv
// Upstream valid/ready word bus plus downstream enable/data drive and FIFO status for reg_feeder.
// Master is the upstream/downstream environment; slave is the feeder itself.
interface reg_feeder_if #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
);
  import reg_feeder_pkg::*;

  localparam int LVL_W = lvl_w(DEPTH);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             stall;
  logic             flush;
  logic             enable;
  logic [WIDTH-1:0] data;
  logic [LVL_W-1:0] level;
  logic             empty;
  logic             full;

  modport master (
    output in_valid, in_data, stall, flush,
    input  in_ready, enable, data, level, empty, full
  );

  modport slave (
    input  in_valid, in_data, stall, flush,
    output in_ready, enable, data, level, empty, full
  );

endinterface

// File: rtl/reg_feeder_fifo.sv
// Circular word buffer with occupancy count; read data is mem[rd_ptr], combinational.
// Caller qualifies push/pop; flush and reset clear pointers and drop a same-cycle push.
module reg_feeder_fifo
  import reg_feeder_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  localparam int PTR_W = ptr_w(DEPTH),
  localparam int LVL_W = lvl_w(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic [LVL_W-1:0] level,
  output logic             empty,
  output logic             full
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;

  // DEPTH is a power of two, so natural pointer overflow is the modulo wrap.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      unique case ({push, pop})
        2'b10:   level <= level + LVL_W'(1);
        2'b01:   level <= level - LVL_W'(1);
        default: level <= level;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push && !flush && !reset) mem[wr_ptr] <= wdata;
  end

  assign rdata = mem[rd_ptr];
  assign empty = (level == '0);
  assign full  = (level == LVL_W'(DEPTH));

endmodule

// File: rtl/reg_feeder.sv
// Buffers upstream words and replays each as a one-cycle enable/data pulse; accept-to-enable is one edge when idle.
// in_ready is !full with no look-ahead; stall and the GAP idle counter hold pops, flush clears everything.
module reg_feeder
  import reg_feeder_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  parameter int GAP   = 0
) (
  input  logic          clk,
  input  logic          reset,
  reg_feeder_if.slave   bus
);

  localparam int LVL_W = lvl_w(DEPTH);

  typedef logic [WIDTH-1:0] word_t;

  word_t            rdata;
  logic [LVL_W-1:0] level;
  logic             empty;
  logic             full;
  logic             push;
  logic             pop;
  logic [GAP_W-1:0] gap_cnt;
  logic             enable_q;
  word_t            data_q;

  assign bus.in_ready = !full;
  assign push = bus.in_valid && !full;
  assign pop  = !empty && !bus.stall && (gap_cnt == '0) && !bus.flush;

  reg_feeder_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .flush (bus.flush),
    .wdata (bus.in_data),
    .rdata (rdata),
    .level (level),
    .empty (empty),
    .full  (full)
  );

  // The gap counter runs down independently of stall so a long stall never adds extra idle time.
  always_ff @(posedge clk) begin
    if (reset) begin
      enable_q <= 1'b0;
      data_q   <= '0;
      gap_cnt  <= '0;
    end else if (bus.flush) begin
      enable_q <= 1'b0;
      gap_cnt  <= '0;
    end else if (pop) begin
      enable_q <= 1'b1;
      data_q   <= rdata;
      gap_cnt  <= GAP_W'(GAP);
    end else begin
      enable_q <= 1'b0;
      if (gap_cnt != '0) gap_cnt <= gap_cnt - GAP_W'(1);
    end
  end

  assign bus.enable = enable_q;
  assign bus.data   = data_q;
  assign bus.level  = level;
  assign bus.empty  = empty;
  assign bus.full   = full;

endmodule

// File: tb/tb_reg_feeder.sv
// Drives a GAP=0 and a GAP=3 feeder; table rows carry hand-derived outputs, a queue checks delivered word order.
module tb_reg_feeder;

  logic clk;
  logic reset;

  reg_feeder_if #(.WIDTH(8), .DEPTH(4)) b0 ();
  reg_feeder_if #(.WIDTH(8), .DEPTH(4)) b1 ();

  reg_feeder #(.WIDTH(8), .DEPTH(4), .GAP(0)) u0 (.clk(clk), .reset(reset), .bus(b0));
  reg_feeder #(.WIDTH(8), .DEPTH(4), .GAP(3)) u1 (.clk(clk), .reset(reset), .bus(b1));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Stand-in for the downstream register slice.
  logic [7:0] outa;
  always @(posedge clk) begin
    if (reset) outa <= 8'h00;
    else if (b0.enable) outa <= b0.data;
  end

  int total = 0;
  int bad   = 0;
  logic [7:0] sb0[$];
  logic [7:0] sb1[$];

  typedef struct {
    logic       v;
    logic [7:0] d;
    logic       s;
    logic       f;
    logic       rdy;
    logic       en;
    logic [2:0] lvl;
    logic [7:0] dat;
    logic [7:0] oa;
  } vec_t;

  vec_t vq[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic add(input logic v, input logic [7:0] d, input logic s, input logic f,
                     input logic rdy, input logic en, input logic [2:0] lvl,
                     input logic [7:0] dat, input logic [7:0] oa);
    vec_t r;
    r.v = v; r.d = d; r.s = s; r.f = f; r.rdy = rdy;
    r.en = en; r.lvl = lvl; r.dat = dat; r.oa = oa;
    vq.push_back(r);
  endtask

  task automatic sb0_check(input string nm);
    logic [7:0] e;
    if (b0.enable) begin
      if (sb0.size() == 0) begin
        chk({nm, "_unexpected_word"}, 32'(b0.data), 32'hFFFF_FFFF);
      end else begin
        e = sb0.pop_front();
        chk({nm, "_order"}, 32'(b0.data), 32'(e));
      end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    int pulses[$];
    int peak;
    logic [7:0] e;

    // single word, fill/wrap, simultaneous push/pop, flush
    add(1, 8'hA5, 0, 0, 1, 0, 1, 8'h00, 8'h00);
    add(0, 8'h00, 0, 0, 1, 1, 0, 8'hA5, 8'h00);
    add(0, 8'h00, 0, 0, 1, 0, 0, 8'hA5, 8'hA5);
    add(1, 8'h01, 1, 0, 1, 0, 1, 8'hA5, 8'hA5);
    add(1, 8'h02, 1, 0, 1, 0, 2, 8'hA5, 8'hA5);
    add(1, 8'h03, 1, 0, 1, 0, 3, 8'hA5, 8'hA5);
    add(1, 8'h04, 1, 0, 1, 0, 4, 8'hA5, 8'hA5);
    add(1, 8'h05, 1, 0, 0, 0, 4, 8'hA5, 8'hA5);
    add(0, 8'h00, 0, 0, 0, 1, 3, 8'h01, 8'hA5);
    add(0, 8'h00, 0, 0, 1, 1, 2, 8'h02, 8'h01);
    add(0, 8'h00, 0, 0, 1, 1, 1, 8'h03, 8'h02);
    add(0, 8'h00, 0, 0, 1, 1, 0, 8'h04, 8'h03);
    add(1, 8'h06, 0, 0, 1, 0, 1, 8'h04, 8'h04);
    add(1, 8'h07, 0, 0, 1, 1, 1, 8'h06, 8'h04);
    add(1, 8'h08, 0, 0, 1, 1, 1, 8'h07, 8'h06);
    add(0, 8'h00, 0, 0, 1, 1, 0, 8'h08, 8'h07);
    add(0, 8'h00, 0, 0, 1, 0, 0, 8'h08, 8'h08);
    add(1, 8'h20, 1, 0, 1, 0, 1, 8'h08, 8'h08);
    add(1, 8'h21, 1, 0, 1, 0, 2, 8'h08, 8'h08);
    add(1, 8'h22, 0, 0, 1, 1, 2, 8'h20, 8'h08);
    add(0, 8'h00, 1, 0, 1, 0, 2, 8'h20, 8'h20);
    add(0, 8'h00, 0, 0, 1, 1, 1, 8'h21, 8'h20);
    add(0, 8'h00, 0, 0, 1, 1, 0, 8'h22, 8'h21);
    add(0, 8'h00, 0, 0, 1, 0, 0, 8'h22, 8'h22);
    add(1, 8'h30, 1, 0, 1, 0, 1, 8'h22, 8'h22);
    add(1, 8'h31, 1, 0, 1, 0, 2, 8'h22, 8'h22);
    add(1, 8'h32, 1, 0, 1, 0, 3, 8'h22, 8'h22);
    add(1, 8'h33, 0, 1, 1, 0, 0, 8'h22, 8'h22);
    add(0, 8'h00, 0, 0, 1, 0, 0, 8'h22, 8'h22);
    add(1, 8'h7E, 0, 0, 1, 0, 1, 8'h22, 8'h22);
    add(0, 8'h00, 0, 0, 1, 1, 0, 8'h7E, 8'h22);
    add(0, 8'h00, 0, 0, 1, 0, 0, 8'h7E, 8'h7E);

    // reset with in_valid held high on both feeders
    reset = 1'b1;
    b0.in_valid = 1'b1; b0.in_data = 8'h55; b0.stall = 1'b0; b0.flush = 1'b0;
    b1.in_valid = 1'b1; b1.in_data = 8'h55; b1.stall = 1'b0; b1.flush = 1'b0;
    for (int c = 0; c < 2; c++) begin
      @(posedge clk); #1;
      chk("rst_enable", 32'(b0.enable), 32'd0);
      chk("rst_data", 32'(b0.data), 32'd0);
      chk("rst_level", 32'(b0.level), 32'd0);
      chk("rst_in_ready", 32'(b0.in_ready), 32'd1);
      chk("rst_empty", 32'(b0.empty), 32'd1);
      chk("rst_full", 32'(b0.full), 32'd0);
      chk("rst_level_g3", 32'(b1.level), 32'd0);
    end
    reset = 1'b0;
    b1.in_valid = 1'b0;

    foreach (vq[i]) begin
      b0.in_valid = vq[i].v;
      b0.in_data  = vq[i].d;
      b0.stall    = vq[i].s;
      b0.flush    = vq[i].f;
      chk($sformatf("row%0d_in_ready", i), 32'(b0.in_ready), 32'(vq[i].rdy));
      if (vq[i].f) sb0.delete();
      else if (vq[i].v && vq[i].rdy) sb0.push_back(vq[i].d);
      @(posedge clk); #1;
      chk($sformatf("row%0d_enable", i), 32'(b0.enable), 32'(vq[i].en));
      chk($sformatf("row%0d_level", i), 32'(b0.level), 32'(vq[i].lvl));
      chk($sformatf("row%0d_empty", i), 32'(b0.empty), 32'(vq[i].lvl == 3'd0));
      chk($sformatf("row%0d_full", i), 32'(b0.full), 32'(vq[i].lvl == 3'd4));
      chk($sformatf("row%0d_data", i), 32'(b0.data), 32'(vq[i].dat));
      chk($sformatf("row%0d_outa", i), 32'(outa), 32'(vq[i].oa));
      sb0_check($sformatf("row%0d", i));
    end
    chk("sb0_drained", 32'(sb0.size()), 32'd0);

    // reset mid-operation discards buffered words
    b0.flush = 1'b0;
    b0.stall = 1'b1;
    for (int c = 0; c < 2; c++) begin
      b0.in_valid = 1'b1;
      b0.in_data  = 8'h40 + 8'(c);
      @(posedge clk); #1;
    end
    chk("pre_reset_level", 32'(b0.level), 32'd2);
    b0.in_valid = 1'b0;
    b0.stall    = 1'b0;
    reset       = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    chk("midrst_level", 32'(b0.level), 32'd0);
    chk("midrst_enable", 32'(b0.enable), 32'd0);
    chk("midrst_data", 32'(b0.data), 32'd0);
    @(posedge clk); #1;
    chk("post_rst_enable", 32'(b0.enable), 32'd0);
    chk("post_rst_level", 32'(b0.level), 32'd0);

    // GAP=3: back-to-back pushes emerge 4 cycles apart
    peak = 0;
    for (int i = 0; i < 14; i++) begin
      b1.in_valid = (i < 3);
      b1.in_data  = 8'h10 + 8'(i);
      if (i < 3) sb1.push_back(8'h10 + 8'(i));
      @(posedge clk); #1;
      if (int'(b1.level) > peak) peak = int'(b1.level);
      if (b1.enable) begin
        pulses.push_back(i);
        if (sb1.size() == 0) begin
          chk("g3_unexpected_word", 32'(b1.data), 32'hFFFF_FFFF);
        end else begin
          e = sb1.pop_front();
          chk("g3_order", 32'(b1.data), 32'(e));
        end
      end
    end
    b1.in_valid = 1'b0;
    chk("g3_pulse_count", 32'(pulses.size()), 32'd3);
    if (pulses.size() >= 3) begin
      chk("g3_pulse0", 32'(pulses[0]), 32'd1);
      chk("g3_pulse1", 32'(pulses[1]), 32'd5);
      chk("g3_pulse2", 32'(pulses[2]), 32'd9);
    end
    chk("g3_level_peak", 32'(peak), 32'd2);
    chk("g3_empty_end", 32'(b1.empty), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
